alu_multicycle: RTL
===================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width in bits; legal values 8, 16, 32, 64.
REQ-002 SHALL have derived localparam SHW = clog2(WIDTH), the shift-amount width (4 at WIDTH=16).
REQ-003 SHALL have port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_valid  input  1  request valid.
REQ-006 SHALL have port o_ready  output  1  request accepted when i_valid && o_ready at a rising edge.
REQ-007 SHALL have port i_opcode  input  4  operation select.
REQ-008 SHALL have ports i_wordA and i_wordB, each input, WIDTH bits: operands A and B.
REQ-009 SHALL have port o_valid  output  1  result valid.
REQ-010 SHALL have port i_ready  input  1  consumer accepts the result when o_valid && i_ready.
REQ-011 SHALL have port o_result  output  WIDTH  registered result.
REQ-012 SHALL have ports o_flag_zero, o_flag_sign, o_flag_overflow and o_flag_carry, each output, 1 bit: registered flags.

Function
REQ-013 SHALL implement opcodes 0x0 ADD, 0x1 SUB, 0x2 AND, 0x3 OR, 0x4 XOR, 0x5 SLL, 0x6 SRL, 0x7 SRA, 0x8 SLT (signed), 0x9 SLTU, 0xA MUL (low WIDTH bits of the unsigned product), 0xB MULHU (high WIDTH bits), 0xC DIVU (unsigned quotient), 0xD REMU (unsigned remainder); 0xE and 0xF yield result 0.
REQ-014 Shifts SHALL use i_wordB[SHW-1:0] only; SLT and SLTU SHALL yield 1 or 0, zero-extended to WIDTH.
REQ-015 SHALL use a three-state FSM: IDLE, BUSY and DONE; o_ready = (state==IDLE), combinational from state.
REQ-016 On acceptance SHALL capture opcode, A and B into internal registers; input changes after acceptance SHALL NOT affect the result.
REQ-017 Opcodes other than 0xA-0xD SHALL go IDLE->DONE, with o_valid asserted the cycle after acceptance (latency 1).
REQ-018 Opcodes 0xA-0xD SHALL go IDLE->BUSY and iterate one bit per cycle for exactly WIDTH cycles: MUL/MULHU by shift-add into a 2*WIDTH product, DIVU/REMU by restoring division. They SHALL then go BUSY->DONE, with o_valid asserted WIDTH+1 cycles after acceptance.
REQ-019 The iteration counter SHALL be SHW+1 bits, loaded at acceptance and decremented in BUSY; BUSY exits when the counter reaches zero.
REQ-020 In DONE, o_valid=1 and o_result plus all flags SHALL hold stable until i_ready=1, then go DONE->IDLE on that edge. o_ready therefore rises the cycle after the handoff; there is no same-cycle re-accept.
REQ-021 i_valid SHALL be ignored in BUSY and DONE; i_ready SHALL be ignored outside DONE.
REQ-022 o_flag_zero = (result==0); o_flag_sign = result[WIDTH-1].
REQ-023 o_flag_carry SHALL be the carry-out for ADD, the borrow (A<B unsigned) for SUB, and 0 otherwise.
REQ-024 o_flag_overflow SHALL be two's-complement overflow for ADD and SUB, 1 for MUL when the high half is nonzero, 1 for DIVU/REMU when B==0, and 0 otherwise.
REQ-025 Divide by zero SHALL complete in the normal WIDTH+1 latency, with DIVU result all-ones and REMU result = A.
REQ-026 Result and flags SHALL update only on the BUSY->DONE or IDLE->DONE transition.

Reset
REQ-027 i_rst_n low SHALL immediately force state IDLE, o_valid=0, o_result=0, all flags=0, counter=0 and internal operand/product registers to 0, so o_ready=1.
REQ-028 Reset asserted mid-BUSY or in DONE SHALL abandon the operation with no result produced; the first accepted request after reset release SHALL compute correctly.

Verification (WIDTH=16)
REQ-029 ADD A=0x7FFF, B=0x0001: o_valid one cycle after accept, result 0x8000, overflow=1, sign=1, carry=0, zero=0. SUB 0x0000-0x0001: result 0xFFFF, carry=1, overflow=0.
REQ-030 MUL A=0x1234, B=0x0100: o_ready low for 17 cycles, o_valid exactly 17 cycles after accept, result 0x3400, overflow=1. MULHU with the same operands: result 0x0012.
REQ-031 DIVU 100/7 -> 0x000E and REMU -> 0x0002. DIVU 0x1234/0 -> 0xFFFF with overflow=1. REMU 5/0 -> 0x0005.
REQ-032 SRA A=0x8000, B=0x0013 (shamt 3) -> 0xF000. SLT 0xFFFF vs 0x0001 -> 1. SLTU with the same operands -> 0.
REQ-033 Backpressure: hold i_ready=0 for 5 cycles in DONE while driving i_valid=1 with new operands -> o_result and flags unchanged, o_ready=0, no request accepted. Then i_ready=1 -> IDLE on the next edge.
REQ-034 Assert i_rst_n=0 on cycle 8 of a DIVU -> o_valid=0 and o_ready=1 asynchronously. After release, ADD 2+3 -> 0x0005 with latency 1.

Source files
------------

// File: rtl/alu_multicycle_if.sv
// Request/response bundle for alu_multicycle: request handshake with operands,
// result handshake with registered result and flags.
interface alu_multicycle_if #(
    parameter int unsigned WIDTH = 16
);
    logic             i_valid;
    logic             o_ready;
    logic [3:0]       i_opcode;
    logic [WIDTH-1:0] i_wordA;
    logic [WIDTH-1:0] i_wordB;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_result;
    logic             o_flag_zero;
    logic             o_flag_sign;
    logic             o_flag_overflow;
    logic             o_flag_carry;

    modport slave (
        input  i_valid, i_opcode, i_wordA, i_wordB, i_ready,
        output o_ready, o_valid, o_result,
               o_flag_zero, o_flag_sign, o_flag_overflow, o_flag_carry
    );

    modport master (
        output i_valid, i_opcode, i_wordA, i_wordB, i_ready,
        input  o_ready, o_valid, o_result,
               o_flag_zero, o_flag_sign, o_flag_overflow, o_flag_carry
    );
endinterface

// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle logic/add/shift ops, bit-serial multiply and
// restoring divide over WIDTH iterations, with a valid/ready result hold.
module alu_multicycle #(
    parameter int unsigned WIDTH = 16
) (
    input logic              i_clk,
    input logic              i_rst_n,
    alu_multicycle_if.slave  bus
);
    localparam int unsigned SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e             state_q, state_d;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [SHW:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [3:0]         flags_q, flags_d;  // {zero, sign, overflow, carry}

    logic               accept, in_multi;
    logic [WIDTH:0]     sum, diff;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   quick_res;
    logic               quick_ovf, quick_carry;

    logic [WIDTH:0]     mul_sum, rem_sh, rem_sub;
    logic               rem_ge;
    logic [2*WIDTH-1:0] mul_next, div_next, step;
    logic [WIDTH-1:0]   multi_res;
    logic               multi_ovf;

    assign accept   = (state_q == StIdle) && bus.i_valid;
    assign in_multi = (bus.i_opcode >= 4'hA) && (bus.i_opcode <= 4'hD);

    // Single-cycle ops read the live inputs; they are only used on the accept edge.
    always_comb begin
        sum         = {1'b0, bus.i_wordA} + {1'b0, bus.i_wordB};
        diff        = {1'b0, bus.i_wordA} - {1'b0, bus.i_wordB};
        shamt       = bus.i_wordB[SHW-1:0];
        quick_res   = '0;
        quick_ovf   = 1'b0;
        quick_carry = 1'b0;
        case (bus.i_opcode)
            4'h0: begin
                quick_res   = sum[WIDTH-1:0];
                quick_carry = sum[WIDTH];
                quick_ovf   = (bus.i_wordA[WIDTH-1] == bus.i_wordB[WIDTH-1]) &&
                              (sum[WIDTH-1] != bus.i_wordA[WIDTH-1]);
            end
            4'h1: begin
                quick_res   = diff[WIDTH-1:0];
                quick_carry = diff[WIDTH];
                quick_ovf   = (bus.i_wordA[WIDTH-1] != bus.i_wordB[WIDTH-1]) &&
                              (diff[WIDTH-1] != bus.i_wordA[WIDTH-1]);
            end
            4'h2: quick_res = bus.i_wordA & bus.i_wordB;
            4'h3: quick_res = bus.i_wordA | bus.i_wordB;
            4'h4: quick_res = bus.i_wordA ^ bus.i_wordB;
            4'h5: quick_res = bus.i_wordA << shamt;
            4'h6: quick_res = bus.i_wordA >> shamt;
            4'h7: quick_res = $unsigned($signed(bus.i_wordA) >>> shamt);
            4'h8: quick_res = {{(WIDTH-1){1'b0}}, $signed(bus.i_wordA) < $signed(bus.i_wordB)};
            4'h9: quick_res = {{(WIDTH-1){1'b0}}, bus.i_wordA < bus.i_wordB};
            default: quick_res = '0;
        endcase
    end

    // One iteration: multiply adds A into the upper half and shifts the product right;
    // divide shifts the next dividend bit into the partial remainder and trial-subtracts B.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_sub  = rem_sh - {1'b0, b_q};
        rem_ge   = rem_sh >= {1'b0, b_q};
        div_next = {(rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                    acc_q[WIDTH-2:0], rem_ge};
        step     = op_q[2] ? div_next : mul_next;
        multi_ovf = 1'b0;
        case (op_q)
            4'hA: begin
                multi_res = step[WIDTH-1:0];
                multi_ovf = |step[2*WIDTH-1:WIDTH];
            end
            4'hB: multi_res = step[2*WIDTH-1:WIDTH];
            4'hC: begin
                multi_res = step[WIDTH-1:0];
                multi_ovf = (b_q == '0);
            end
            4'hD: begin
                multi_res = step[2*WIDTH-1:WIDTH];
                multi_ovf = (b_q == '0);
            end
            default: multi_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        res_d   = res_q;
        flags_d = flags_q;
        unique case (state_q)
            StIdle: begin
                if (bus.i_valid) begin
                    if (in_multi) begin
                        state_d = StBusy;
                        cnt_d   = (SHW+1)'(WIDTH);
                        acc_d   = bus.i_opcode[2] ? {{WIDTH{1'b0}}, bus.i_wordA}
                                                  : {{WIDTH{1'b0}}, bus.i_wordB};
                    end else begin
                        state_d = StDone;
                        res_d   = quick_res;
                        flags_d = {quick_res == '0, quick_res[WIDTH-1], quick_ovf, quick_carry};
                    end
                end
            end
            StBusy: begin
                acc_d = step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_d == '0) begin
                    state_d = StDone;
                    res_d   = multi_res;
                    flags_d = {multi_res == '0, multi_res[WIDTH-1], multi_ovf, 1'b0};
                end
            end
            StDone: begin
                if (bus.i_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            flags_q <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            if (accept) begin
                op_q <= bus.i_opcode;
                a_q  <= bus.i_wordA;
                b_q  <= bus.i_wordB;
            end
        end
    end

    assign bus.o_ready         = (state_q == StIdle);
    assign bus.o_valid         = (state_q == StDone);
    assign bus.o_result        = res_q;
    assign bus.o_flag_zero     = flags_q[3];
    assign bus.o_flag_sign     = flags_q[2];
    assign bus.o_flag_overflow = flags_q[1];
    assign bus.o_flag_carry    = flags_q[0];
endmodule
